// File: rtl/gene_ascii_packer_if.sv
// ---------------------------------------------------------------------------
// gene_ascii_packer_if
//   Bundles both stream sides of the ASCII-to-2-bit nucleotide packer.
//
//   Character side (source -> packer):
//     in_char   [7:0]  ASCII nucleotide byte
//     in_valid         in_char / in_last are valid
//     in_last          final character of the sequence, forces a flush
//     in_ready         packer can take a beat (driven by the packer)
//
//   Word side (packer -> sink):
//     out_word  [2N-1:0]  packed codes, first base in the MSBs
//     out_count [CNT_W-1:0] number of valid bases in out_word
//     out_last            word closes the sequence
//     out_valid           output register holds a word
//     out_ready           sink accepts the word (driven by the sink)
//
//   Status:
//     err_char         one-cycle pulse after an unmapped byte was accepted
//
//   Modports:
//     master : the environment around the packer (byte source + word sink)
//     slave  : the packer itself
// ---------------------------------------------------------------------------
interface gene_ascii_packer_if #(
  parameter int BASES_PER_WORD = 4,
  parameter int CNT_W          = 3
);

  logic [7:0]                    in_char;
  logic                          in_valid;
  logic                          in_last;
  logic                          in_ready;

  logic [2*BASES_PER_WORD-1:0]   out_word;
  logic [CNT_W-1:0]              out_count;
  logic                          out_last;
  logic                          out_valid;
  logic                          out_ready;

  logic                          err_char;

  modport master (
    output in_char,
    output in_valid,
    output in_last,
    input  in_ready,
    input  out_word,
    input  out_count,
    input  out_last,
    input  out_valid,
    output out_ready,
    input  err_char
  );

  modport slave (
    input  in_char,
    input  in_valid,
    input  in_last,
    output in_ready,
    output out_word,
    output out_count,
    output out_last,
    output out_valid,
    input  out_ready,
    output err_char
  );

endinterface

// File: rtl/gene_ascii_packer.sv
// ---------------------------------------------------------------------------
// gene_ascii_packer
//   Streaming encoder between the raw FASTA byte source and the compressed
//   word store. Each accepted ASCII nucleotide is mapped to a 2-bit code
//   (A=00, C=01, T=10, G=11, upper or lower case) and packed MSB-first into
//   a word of BASES_PER_WORD codes. A word is emitted when it fills up or
//   when a beat carrying in_last is accepted (partial words are zero-padded
//   in the LSBs; an empty accumulator flushes as out_count=0).
//   This is the inverse of the 2-bit-to-ASCII expander and shares its map.
//
//   Parameters:
//     BASES_PER_WORD  bases per output word (>= 2), word width 2*N
//     CNT_W           width of out_count (>= clog2(N+1))
//
//   Ports:
//     clk   sole clock, rising edge
//     rst   synchronous active-high reset; drops any partial word and any
//           pending output word without flushing
//     bus   gene_ascii_packer_if.slave, see the interface header
//
//   Timing:
//     - in_ready = !out_valid || out_ready, so a stalled sink stalls the
//       source even mid-word and no beat is ever lost.
//     - One cycle from the completing beat to out_valid; one char/cycle
//       sustained while the sink is ready.
//     - err_char is registered: it pulses the cycle after the bad byte.
// ---------------------------------------------------------------------------
module gene_ascii_packer #(
  parameter int BASES_PER_WORD = 4,
  parameter int CNT_W          = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  gene_ascii_packer_if.slave   bus
);

  localparam int              WORD_W    = 2 * BASES_PER_WORD;
  localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(BASES_PER_WORD - 1);

  // Returns {is_nucleotide, code[1:0]}; unmapped bytes give is_nucleotide=0.
  function automatic logic [2:0] map_char(input logic [7:0] ch);
    logic [2:0] res;
    case (ch)
      8'h41, 8'h61: res = 3'b1_00;  // A / a
      8'h43, 8'h63: res = 3'b1_01;  // C / c
      8'h54, 8'h74: res = 3'b1_10;  // T / t
      8'h47, 8'h67: res = 3'b1_11;  // G / g
      default:      res = 3'b0_00;
    endcase
    return res;
  endfunction

  // Accumulator state
  logic [WORD_W-1:0] acc_r;
  logic [CNT_W-1:0]  cnt_r;

  // Output register
  logic [WORD_W-1:0] out_word_r;
  logic [CNT_W-1:0]  out_count_r;
  logic              out_last_r;
  logic              out_valid_r;
  logic              err_char_r;

  // Combinational helpers
  logic [2:0]        map_s;
  logic              char_ok_s;
  logic [1:0]        code_s;
  logic              in_ready_s;
  logic              accept_s;
  logic              base_s;
  logic              complete_s;
  logic              drain_s;
  logic [WORD_W-1:0] acc_ins_s;
  logic [CNT_W-1:0]  cnt_ins_s;

  // Decode the incoming byte and derive the handshake events of this cycle.
  always_comb begin
    map_s      = map_char(bus.in_char);
    char_ok_s  = map_s[2];
    code_s     = map_s[1:0];
    // The output register frees up in the same cycle it drains, so a word
    // can be taken and a new one loaded back to back.
    in_ready_s = !out_valid_r || bus.out_ready;
    accept_s   = bus.in_valid && in_ready_s;
    base_s     = accept_s && char_ok_s;
    // Completion on a full word or on in_last; a bad byte never fills the
    // word but its in_last still flushes whatever is held.
    complete_s = accept_s && (bus.in_last || (char_ok_s && (cnt_r == LAST_SLOT)));
    drain_s    = out_valid_r && bus.out_ready;
  end

  // Accumulator contents after inserting the current base (if any).
  always_comb begin
    acc_ins_s = acc_r;
    cnt_ins_s = cnt_r;
    if (base_s) begin
      cnt_ins_s = cnt_r + CNT_W'(1);
      // Base k lands in bits [2N-1-2k : 2N-2-2k]; slots past cnt_r are
      // still zero, which is what pads a partial word.
      for (int k = 0; k < BASES_PER_WORD; k++) begin
        if (cnt_r == CNT_W'(k)) begin
          acc_ins_s[WORD_W-1-2*k -: 2] = code_s;
        end else begin
          acc_ins_s[WORD_W-1-2*k -: 2] = acc_r[WORD_W-1-2*k -: 2];
        end
      end
    end else begin
      acc_ins_s = acc_r;
      cnt_ins_s = cnt_r;
    end
  end

  // Accumulator register: clears on every completion, so the count stays <= N.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_r <= '0;
      cnt_r <= '0;
    end else if (complete_s) begin
      acc_r <= '0;
      cnt_r <= '0;
    end else begin
      acc_r <= acc_ins_s;
      cnt_r <= cnt_ins_s;
    end
  end

  // Output register: load on completion (even while draining), else clear
  // valid when the sink takes the word, else hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_word_r  <= '0;
      out_count_r <= '0;
      out_last_r  <= 1'b0;
      out_valid_r <= 1'b0;
    end else if (complete_s) begin
      out_word_r  <= acc_ins_s;
      out_count_r <= cnt_ins_s;
      out_last_r  <= bus.in_last;
      out_valid_r <= 1'b1;
    end else if (drain_s) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  // Error pulse: one cycle after an unmapped byte is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_char_r <= 1'b0;
    end else begin
      err_char_r <= accept_s && !char_ok_s;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_word  = out_word_r;
  assign bus.out_count = out_count_r;
  assign bus.out_last  = out_last_r;
  assign bus.out_valid = out_valid_r;
  assign bus.err_char  = err_char_r;

endmodule

// File: tb/tb_gene_ascii_packer.sv
// ---------------------------------------------------------------------------
// tb_gene_ascii_packer
//   Directed bench for gene_ascii_packer with hand-computed expected words.
//   Inputs change 1 time unit after the rising edge; the sink monitor and all
//   checks sample on the falling edge.
// ---------------------------------------------------------------------------
module tb_gene_ascii_packer;

  localparam int N     = 4;
  localparam int CNT_W = 3;

  typedef struct packed {
    logic             last;
    logic [CNT_W-1:0] count;
    logic [2*N-1:0]   word;
  } word_t;

  logic clk;
  logic rst;

  gene_ascii_packer_if #(.BASES_PER_WORD(N), .CNT_W(CNT_W)) bus ();

  gene_ascii_packer #(.BASES_PER_WORD(N), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int    n_checks;
  int    n_errors;
  int    cyc;
  int    err_cnt;
  int    err_cyc;
  int    acc_cyc;
  word_t rx_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counter, advanced on each rising edge.
  always @(posedge clk) cyc <= cyc + 1;

  // Sink monitor: whatever handshakes at the next rising edge is visible here.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      rx_q.push_back('{last: bus.out_last, count: bus.out_count, word: bus.out_word});
    end
    if (bus.err_char) begin
      err_cnt = err_cnt + 1;
      err_cyc = cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present one beat and hold it until accepted (bounded).
  task automatic send(input logic [7:0] ch, input logic last);
    int t;
    bus.in_char  = ch;
    bus.in_valid = 1'b1;
    bus.in_last  = last;
    t = 0;
    @(negedge clk);
    while (!bus.in_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (t >= 300) check("send_timeout", 32'(t), 32'(0));
    acc_cyc = cyc + 1;
    @(posedge clk);
    #1;
  endtask

  task automatic send_str(input string s, input bit last_on_final);
    for (int i = 0; i < s.len(); i++) begin
      send(s[i], last_on_final && (i == s.len() - 1));
    end
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_char  = 8'h00;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Pop the next received word and compare all of its fields.
  task automatic expect_word(input string tag, input logic [7:0] w,
                             input logic [CNT_W-1:0] c, input logic l);
    word_t r;
    check({tag, "_avail"}, 32'(rx_q.size() > 0), 32'(1));
    if (rx_q.size() > 0) begin
      r = rx_q.pop_front();
      check({tag, "_word"},  32'(r.word),  32'(w));
      check({tag, "_count"}, 32'(r.count), 32'(c));
      check({tag, "_last"},  32'(r.last),  32'(l));
    end
  endtask

  initial begin
    int err0;
    n_checks = 0;
    n_errors = 0;
    cyc      = 0;
    err_cnt  = 0;
    err_cyc  = -1;
    acc_cyc  = 0;
    rst          = 1'b1;
    bus.in_char  = 8'h00;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_out_valid", 32'(bus.out_valid), 32'(0));
    check("rst_out_word",  32'(bus.out_word),  32'(0));
    check("rst_out_count", 32'(bus.out_count), 32'(0));
    check("rst_out_last",  32'(bus.out_last),  32'(0));
    check("rst_err_char",  32'(bus.err_char),  32'(0));
    check("rst_in_ready",  32'(bus.in_ready),  32'(1));
    @(posedge clk);
    #1;

    // CGTA: word one cycle after 'A'
    send_str("CGTA", 1'b0);
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("cgta_latency_valid", 32'(bus.out_valid), 32'(1));
    check("cgta_latency_word",  32'(bus.out_word),  32'(8'h78));
    idle(2);
    expect_word("cgta", 8'h78, 3'd4, 1'b0);

    // ACGT back to back with 1 char/cycle
    begin
      int c0;
      c0 = cyc;
      send_str("ACGT", 1'b0);
      check("acgt_throughput", 32'(cyc - c0), 32'(4));
    end
    idle(2);
    expect_word("acgt", 8'h1E, 3'd4, 1'b0);

    // Lowercase with in_last on the final base
    send_str("ggca", 1'b1);
    idle(2);
    expect_word("ggca", 8'hF4, 3'd4, 1'b1);
    check("ggca_no_err", 32'(err_cnt), 32'(0));

    // Partial flush
    send_str("GG", 1'b1);
    idle(2);
    expect_word("gg_partial", 8'hF0, 3'd2, 1'b1);

    // Invalid byte in the middle: skipped, one err pulse the cycle after it
    err0 = err_cnt;
    send("A", 1'b0);
    send(8'h4E, 1'b0);
    begin
      int n_cyc;
      n_cyc = acc_cyc;
      send_str("CGT", 1'b0);
      idle(2);
      check("bad_err_pulses", 32'(err_cnt - err0), 32'(1));
      check("bad_err_cycle",  32'(err_cyc), 32'(n_cyc));
    end
    expect_word("bad_skip", 8'h1E, 3'd4, 1'b0);

    // Invalid byte with in_last on an empty accumulator
    err0 = err_cnt;
    send(8'hFF, 1'b1);
    idle(2);
    expect_word("empty_flush", 8'h00, 3'd0, 1'b1);
    check("empty_flush_err", 32'(err_cnt - err0), 32'(1));

    // Single base with in_last
    send("A", 1'b1);
    idle(2);
    expect_word("single_a", 8'h00, 3'd1, 1'b1);

    // Backpressure: 12 chars, sink stalled then random
    bus.out_ready = 1'b0;
    fork
      begin
        send_str("ACGTACGTACGT", 1'b0);
        bus.in_valid = 1'b0;
      end
      begin
        repeat (6) @(negedge clk);
        check("bp_in_ready_low", 32'(bus.in_ready),  32'(0));
        check("bp_valid_held",   32'(bus.out_valid), 32'(1));
        check("bp_word_held",    32'(bus.out_word),  32'(8'h1E));
        @(posedge clk);
        #1;
        for (int i = 0; i < 60; i++) begin
          bus.out_ready = 1'($urandom_range(0, 1));
          @(posedge clk);
          #1;
        end
        bus.out_ready = 1'b1;
      end
    join
    idle(3);
    check("bp_word_total", 32'(rx_q.size()), 32'(3));
    for (int i = 0; i < 3; i++) begin
      expect_word("bp", 8'h1E, 3'd4, 1'b0);
    end

    // Reset mid-word: the CG prefix must vanish
    err0 = err_cnt;
    send_str("CG", 1'b0);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_valid_during", 32'(bus.out_valid), 32'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_valid_after", 32'(bus.out_valid), 32'(0));
    check("mid_rst_err_after",   32'(bus.err_char),  32'(0));
    @(posedge clk);
    #1;
    send_str("TTTT", 1'b0);
    idle(3);
    check("mid_rst_err_none", 32'(err_cnt - err0), 32'(0));
    expect_word("mid_rst", 8'hAA, 3'd4, 1'b0);
    check("final_queue_empty", 32'(rx_q.size()), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/gene_ascii_packer.md
Name: gene_ascii_packer

Overview:
- Streaming encoder: accepts one ASCII nucleotide character per beat and maps it to a 2-bit code.
- Packs BASES_PER_WORD codes into one output word for the compressed store.
- Inverse of the existing 2-bit-to-ASCII expander; uses the same code map: A=00, C=01, T=10, G=11.
- Sits between the raw FASTA byte source and the compressed-word sink; both sides use valid/ready handshakes.

Parameters:
- BASES_PER_WORD, 4: bases packed per output word; must be ≥2. Output width is 2*BASES_PER_WORD.
- CNT_W, 3: width of out_count; must be ≥ clog2(BASES_PER_WORD+1).

Ports:
- clk, input, 1: sole clock, rising edge.
- rst, input, 1: synchronous active-high reset.
- in_char, input, 8: ASCII character.
- in_valid, input, 1: in_char/in_last valid.
- in_last, input, 1: final character of sequence; forces flush.
- in_ready, output, 1: block can accept a beat.
- out_word, output, 2*BASES_PER_WORD: packed codes; first base in MSBs.
- out_count, output, CNT_W: number of valid bases in out_word (0..BASES_PER_WORD).
- out_last, output, 1: word closes the sequence.
- out_valid, output, 1: output register holds a word.
- out_ready, input, 1: sink accepts word.
- err_char, output, 1: one-cycle pulse when an unmapped character was accepted.

Behaviour:
- Reset: out_valid=0, out_word=0, out_count=0, out_last=0, err_char=0. Accumulator and base counter cleared. in_ready=1 on the first cycle after reset.
- Reset mid-word: partial accumulator contents and any pending output word are discarded with no flush.
- Handshake: a beat transfers when in_valid && in_ready. A word transfers when out_valid && out_ready.
- in_ready = !out_valid || out_ready (combinational). Data/control must hold while valid is high and ready is low.
- Map: 0x41/0x61→00; 0x43/0x63→01; 0x54/0x74→10; 0x47/0x67→11. Any other byte is invalid.
- Invalid byte: no base stored, counter unchanged, err_char=1 in the next cycle. in_last on an invalid byte still flushes.
- Packing: the k-th accepted base (k=0..N-1) goes to bits [2N-1-2k : 2N-2-2k]. Unused LSBs of a partial word are 0.
- Word complete when either:
  - the accepted valid base makes the count N, or
  - in_last is accepted.
- On completion: the next cycle has out_valid=1, out_word=packed value, out_count=bases held (0 allowed when in_last lands on an empty accumulator), and out_last=in_last. The accumulator clears the same cycle.
  - Example: 'A' with in_last and an empty accumulator → out_count=1, word 0x00, out_last=1.
- Latency: 1 cycle from the completing input beat to out_valid.
- Throughput: 1 char/cycle sustained while out_ready=1.
- Simultaneous events: an output drain and a new completion in the same cycle are allowed. The register reloads and out_valid stays 1.
- Backpressure: out_valid && !out_ready deasserts in_ready, including mid-word; no beat is lost.
- out_word, out_count, out_last, out_valid hold stable until taken.
- No counters wrap: the base counter is bounded by N and resets on every completion.

Test Plan:
- Stream 'C','G','T','A' with out_ready=1:
  - required: one word 0x78, out_count=4, out_last=0, one cycle after 'A'.
  - then 'A','C','G','T' → 0x1E.
- Lowercase 'g','g','c','a' with in_last on 'a' → 0xF4, out_count=4, out_last=1, err_char never set.
- Partial flush 'G','G' with in_last on the second 'G' → 0xF0, out_count=2, out_last=1. Accumulator empty afterwards.
- Invalid input 'A','N'(0x4E),'C','G','T':
  - err_char pulses once, the cycle after 'N'.
  - output is one word 0x1E, out_count=4.
  - 0xFF with in_last on an empty accumulator → word 0x00, out_count=0, out_last=1, plus an err_char pulse.
- Backpressure: hold out_ready=0 while streaming 12 chars "ACGTACGTACGT":
  - after the first word, in_ready=0 and out_word=0x1E holds.
  - toggle out_ready randomly; the sink must receive exactly 0x1E ×3 in order, with no drop or duplicate.
- Reset mid-word: send 'C','G', assert rst for one cycle, then send 'T','T','T','T':
  - required: the only word is 0xAA.
  - during and after reset: out_valid=0, err_char=0.
